// File: rtl/dcache_refill_responder.sv
// Purpose: memory-side responder that drains dirty writebacks and refills missed blocks as 4-beat bursts.
// Latency: miss seen in IDLE at cycle 0 -> repair_resolved at cycle 6 minimum; writeback -> wb_ack at cycle 6 minimum.
// Backpressure: holds command/write beat while mem_req_ready/mem_wready low; read beats have no backpressure and gaps are tolerated.
module dcache_refill_responder #(
    parameter int ADDR_W     = 32,
    parameter int BLOCK_BITS = 128,
    parameter int BEAT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss_req,
    input  logic [ADDR_W-1:0]     i_miss_addr,
    output logic                  o_repair_resolved,
    output logic [ADDR_W-1:0]     o_fill_addr,
    output logic [BLOCK_BITS-1:0] o_fill_data,
    input  logic                  i_wb_req,
    input  logic [ADDR_W-1:0]     i_wb_addr,
    input  logic [BLOCK_BITS-1:0] i_wb_data,
    output logic                  o_wb_ack,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_we,
    output logic [ADDR_W-1:0]     o_mem_req_addr,
    output logic                  o_mem_wvalid,
    input  logic                  i_mem_wready,
    output logic [BEAT_BITS-1:0]  o_mem_wdata,
    input  logic                  i_mem_rvalid,
    input  logic [BEAT_BITS-1:0]  i_mem_rdata
);

    localparam int BEATS = BLOCK_BITS / BEAT_BITS;
    // Clears the byte-within-block offset bits.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BLOCK_BITS / 8 - 1);
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_WB_DATA,
        S_WB_DONE,
        S_RD_REQ,
        S_RD_DATA,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [1:0]            r_cnt;
    logic [ADDR_W-1:0]     r_wb_addr;
    logic [BLOCK_BITS-1:0] r_wb_data;
    logic [ADDR_W-1:0]     r_fill_addr;
    logic [BLOCK_BITS-1:0] r_fill_data;
    logic                  r_repair_resolved;
    logic                  r_wb_ack;
    logic                  r_mem_req_valid;
    logic                  r_mem_req_we;
    logic [ADDR_W-1:0]     r_mem_req_addr;
    logic                  r_mem_wvalid;
    logic [BEAT_BITS-1:0]  r_mem_wdata;

    logic [1:0]            w_cnt_inc;
    logic [BEAT_BITS-1:0]  w_wb_beat_next;

    assign w_cnt_inc      = r_cnt + 2'd1;
    // Beat presented after the current one is accepted; only used while the burst is not finished.
    assign w_wb_beat_next = r_wb_data[w_cnt_inc*BEAT_BITS +: BEAT_BITS];

    // Control FSM; every output is a register loaded for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_cnt             <= 2'd0;
            r_wb_addr         <= '0;
            r_wb_data         <= '0;
            r_fill_addr       <= '0;
            r_fill_data       <= '0;
            r_repair_resolved <= 1'b0;
            r_wb_ack          <= 1'b0;
            r_mem_req_valid   <= 1'b0;
            r_mem_req_we      <= 1'b0;
            r_mem_req_addr    <= '0;
            r_mem_wvalid      <= 1'b0;
            r_mem_wdata       <= '0;
        end else begin
            r_repair_resolved <= 1'b0;
            r_wb_ack          <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Writeback first so memory never holds stale data when the refill reads it.
                    if (i_wb_req) begin
                        r_wb_addr       <= i_wb_addr & ALIGN_MASK;
                        r_wb_data       <= i_wb_data;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_we    <= 1'b1;
                        r_mem_req_addr  <= i_wb_addr & ALIGN_MASK;
                        r_state         <= S_WB_REQ;
                    end else if (i_miss_req) begin
                        r_fill_addr     <= i_miss_addr & ALIGN_MASK;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_we    <= 1'b0;
                        r_mem_req_addr  <= i_miss_addr & ALIGN_MASK;
                        r_state         <= S_RD_REQ;
                    end
                end
                S_WB_REQ: begin
                    if (i_mem_req_ready) begin
                        r_cnt           <= 2'd0;
                        r_mem_req_valid <= 1'b0;
                        r_mem_req_we    <= 1'b0;
                        r_mem_req_addr  <= '0;
                        r_mem_wvalid    <= 1'b1;
                        r_mem_wdata     <= r_wb_data[BEAT_BITS-1:0];
                        r_state         <= S_WB_DATA;
                    end
                end
                S_WB_DATA: begin
                    if (i_mem_wready) begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt == LAST_BEAT) begin
                            r_mem_wvalid <= 1'b0;
                            r_mem_wdata  <= '0;
                            r_wb_ack     <= 1'b1;
                            r_state      <= S_WB_DONE;
                        end else begin
                            r_mem_wdata <= w_wb_beat_next;
                        end
                    end
                end
                S_WB_DONE: begin
                    r_state <= S_IDLE;
                end
                S_RD_REQ: begin
                    if (i_mem_req_ready) begin
                        r_cnt           <= 2'd0;
                        r_mem_req_valid <= 1'b0;
                        r_mem_req_addr  <= '0;
                        r_state         <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (i_mem_rvalid) begin
                        r_fill_data[r_cnt*BEAT_BITS +: BEAT_BITS] <= i_mem_rdata;
                        r_cnt <= w_cnt_inc;
                        if (r_cnt == LAST_BEAT) begin
                            r_repair_resolved <= 1'b1;
                            r_state           <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_repair_resolved = r_repair_resolved;
    assign o_fill_addr       = r_fill_addr;
    assign o_fill_data       = r_fill_data;
    assign o_wb_ack          = r_wb_ack;
    assign o_mem_req_valid   = r_mem_req_valid;
    assign o_mem_req_we      = r_mem_req_we;
    assign o_mem_req_addr    = r_mem_req_addr;
    assign o_mem_wvalid      = r_mem_wvalid;
    assign o_mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_dcache_refill_responder.sv
// Bench for dcache_refill_responder: behavioural cache + memory model driving directed and random episodes.
module tb_dcache_refill_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_miss_req;
    logic [31:0]  i_miss_addr;
    logic         o_repair_resolved;
    logic [31:0]  o_fill_addr;
    logic [127:0] o_fill_data;
    logic         i_wb_req;
    logic [31:0]  i_wb_addr;
    logic [127:0] i_wb_data;
    logic         o_wb_ack;
    logic         o_mem_req_valid;
    logic         i_mem_req_ready;
    logic         o_mem_req_we;
    logic [31:0]  o_mem_req_addr;
    logic         o_mem_wvalid;
    logic         i_mem_wready;
    logic [31:0]  o_mem_wdata;
    logic         i_mem_rvalid;
    logic [31:0]  i_mem_rdata;

    dcache_refill_responder #(.ADDR_W(32), .BLOCK_BITS(128), .BEAT_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
        .o_repair_resolved(o_repair_resolved), .o_fill_addr(o_fill_addr), .o_fill_data(o_fill_data),
        .i_wb_req(i_wb_req), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(o_wb_ack),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_we(o_mem_req_we), .o_mem_req_addr(o_mem_req_addr),
        .o_mem_wvalid(o_mem_wvalid), .i_mem_wready(i_mem_wready), .o_mem_wdata(o_mem_wdata),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [31:0] AMASK = 32'hFFFF_FFF0;

    int total = 0;
    int bad   = 0;

    // Cache-side model state
    bit           miss_pend, wb_pend, miss_cmd_seen, wb_cmd_seen;
    logic [31:0]  miss_a0, wb_a0;
    logic [127:0] wb_d0;
    int           miss_t0, wb_t0, exp_rr_lat, exp_wb_lat;
    logic [32:0]  exp_cmds[$];   // {we, aligned addr} in the order memory must see them

    // Memory-side model state
    bit           cmd_armed;
    int           stall_left;
    bit           rd_active, gap_done, rr_due;
    int           rd_idx;
    logic [31:0]  rd_beats[4];
    logic [127:0] exp_fill;
    bit           wr_active, wack_due, prev_wstall, wtog;
    int           wr_idx;
    logic [31:0]  prev_wdata;
    int           n_rr, n_ack, n_wbeats;

    // Knobs
    int fixed_stall = -1, stall_max = 0, gap_at = -1, gap_pct = 0, wready_pct = 100;
    bit wready_toggle, junk, churn, churn_fixed, fixed_beats, hold_rd;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_ctrl", {o_repair_resolved, o_wb_ack, o_mem_req_valid, o_mem_req_we, o_mem_wvalid}, 0);
        chk("rst_fill_addr", o_fill_addr, 0);
        chk("rst_fill_data", o_fill_data, 0);
        chk("rst_req_addr", o_mem_req_addr, 0);
        chk("rst_wdata", o_mem_wdata, 0);
    endtask

    // One cycle of cache + memory behaviour: observe at negedge, then drive the next inputs.
    task automatic tick();
        bit gap;
        bit wr_ok;
        logic [32:0] e;
        @(negedge clk);
        if (o_repair_resolved || rr_due) begin
            chk("rr_pulse", o_repair_resolved, rr_due);
            if (o_repair_resolved) begin
                chk("fill_addr", o_fill_addr, miss_a0 & AMASK);
                chk("fill_data", o_fill_data, exp_fill);
                if (exp_rr_lat >= 0) chk("rr_latency", cyc - miss_t0, exp_rr_lat);
                n_rr++;
                miss_pend  = 0;
                i_miss_req = 0;
            end
        end
        rr_due = 0;
        if (o_wb_ack || wack_due) begin
            chk("wb_ack_pulse", o_wb_ack, wack_due);
            if (o_wb_ack) begin
                if (exp_wb_lat >= 0) chk("wb_latency", cyc - wb_t0, exp_wb_lat);
                n_ack++;
                wb_pend  = 0;
                i_wb_req = 0;
            end
        end
        wack_due = 0;

        // read beats of an accepted read burst (never in the acceptance cycle itself)
        if (rd_active) begin
            if (hold_rd) gap = 1;
            else if (gap_at >= 0) gap = (rd_idx == gap_at) && !gap_done;
            else gap = ($urandom_range(99, 0) < gap_pct);
            if (gap) begin
                i_mem_rvalid = 0;
                i_mem_rdata  = $urandom;
                if (rd_idx == gap_at) gap_done = 1;
            end else begin
                i_mem_rvalid = 1;
                i_mem_rdata  = rd_beats[rd_idx];
                rd_idx++;
                if (rd_idx == 4) begin
                    rd_active = 0;
                    rr_due    = 1;
                end
            end
        end else begin
            i_mem_rvalid = junk ? 1'($urandom_range(1, 0)) : 1'b0;
            i_mem_rdata  = $urandom;
        end

        // command channel
        if (o_mem_req_valid) begin
            if (!cmd_armed) begin
                cmd_armed  = 1;
                stall_left = (fixed_stall >= 0) ? fixed_stall : $urandom_range(stall_max, 0);
            end
            i_mem_req_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (i_mem_req_ready) begin
                cmd_armed = 0;
                chk("cmd_expected", exp_cmds.size() > 0, 1);
                if (exp_cmds.size() > 0) begin
                    e = exp_cmds.pop_front();
                    chk("cmd_we", o_mem_req_we, e[32]);
                    chk("cmd_addr", o_mem_req_addr, e[31:0]);
                    if (!e[32]) begin
                        rd_active = 1; rd_idx = 0; gap_done = 0;
                        for (int i = 0; i < 4; i++)
                            rd_beats[i] = fixed_beats ? 32'h1111_1111 * (i + 1) : $urandom;
                        exp_fill = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
                        miss_cmd_seen = 1;
                    end else begin
                        wr_active = 1; wr_idx = 0; wtog = 1;
                        wb_cmd_seen = 1;
                    end
                end
            end
        end else begin
            chk("req_addr_idle", o_mem_req_addr, 0);
            i_mem_req_ready = junk ? 1'($urandom_range(1, 0)) : 1'b0;
        end

        // write channel
        if (o_mem_wvalid) begin
            chk("wvalid_in_burst", wr_active, 1);
            if (prev_wstall) chk("wdata_hold", o_mem_wdata, prev_wdata);
            wr_ok = wready_toggle ? wtog : ($urandom_range(99, 0) < wready_pct);
            wtog  = !wtog;
            i_mem_wready = wr_ok;
            if (wr_ok && wr_active) begin
                chk("wbeat", o_mem_wdata, wb_d0[wr_idx*32 +: 32]);
                wr_idx++;
                n_wbeats++;
                if (wr_idx == 4) begin
                    wr_active = 0;
                    wack_due  = 1;
                end
            end
            prev_wstall = !wr_ok;
            prev_wdata  = o_mem_wdata;
        end else begin
            i_mem_wready = junk ? 1'($urandom_range(1, 0)) : 1'b0;
            prev_wstall  = 0;
        end

        // cache may change held inputs once the responder has clearly captured them
        if (churn && miss_pend && miss_cmd_seen) i_miss_addr = churn_fixed ? 32'hFFFF_FFF0 : $urandom;
        if (churn && wb_pend && wb_cmd_seen) begin
            i_wb_addr = $urandom;
            i_wb_data = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic start(input bit do_wb, input bit do_miss, input logic [31:0] wa, input logic [127:0] wd,
                         input logic [31:0] ma, input int rr_lat, input int wb_lat);
        if (do_wb) begin
            wb_pend = 1; wb_cmd_seen = 0; wb_a0 = wa; wb_d0 = wd; wb_t0 = cyc;
            i_wb_req = 1; i_wb_addr = wa; i_wb_data = wd;
            exp_cmds.push_back({1'b1, wa & AMASK});
        end
        if (do_miss) begin
            miss_pend = 1; miss_cmd_seen = 0; miss_a0 = ma; miss_t0 = cyc;
            i_miss_req = 1; i_miss_addr = ma;
            exp_cmds.push_back({1'b0, ma & AMASK});
        end
        exp_rr_lat = rr_lat;
        exp_wb_lat = wb_lat;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((miss_pend || wb_pend) && n < 300) begin
            tick();
            n++;
        end
        chk("done_in_time", miss_pend || wb_pend, 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, r0, n;
        rst = 1; i_miss_req = 0; i_miss_addr = 0; i_wb_req = 0; i_wb_addr = 0; i_wb_data = 0;
        i_mem_req_ready = 0; i_mem_wready = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst = 0;
        tick();

        // single miss, ideal memory
        fixed_beats = 1;
        start(0, 1, 0, 0, 32'h0000_1234, 6, -1);
        wait_done();

        // stalled command + gap before beat 2
        fixed_stall = 3; gap_at = 2;
        start(0, 1, 0, 0, 32'h0000_1234, 10, -1);
        wait_done();
        fixed_stall = -1; gap_at = -1;

        // writeback wins over a simultaneous miss
        start(1, 1, 32'h0000_0080, 128'hDDDD_CCCC_BBBB_AAAA, 32'h0000_2008, 13, 6);
        wait_done();

        // write backpressure toggling 1,0,1,0
        wready_toggle = 1; na = n_ack; nb = n_wbeats;
        start(1, 0, 32'h0000_3456, {$urandom, $urandom, $urandom, $urandom}, 0, -1, 9);
        wait_done();
        chk("wtog_beats", n_wbeats - nb, 4);
        chk("wtog_acks", n_ack - na, 1);
        wready_toggle = 0;

        // reset in the middle of a read burst
        start(0, 1, 0, 0, 32'h0000_5678, -1, -1);
        n = 0;
        while (!(rd_active && rd_idx == 3) && n < 50) begin tick(); n++; end
        chk("reached_beat2", rd_active && rd_idx == 3, 1);
        hold_rd = 1;
        tick();
        rst = 1;
        @(negedge clk);
        chk_reset_outs();
        rst = 0;
        rd_active = 0; hold_rd = 0; miss_pend = 0; i_miss_req = 0; rr_due = 0; cmd_armed = 0;
        exp_cmds.delete();
        i_mem_rvalid = 1; i_mem_rdata = 32'hBAD0_BAD0;
        r0 = n_rr;
        repeat (6) tick();
        chk("rr_after_rst", n_rr, r0);
        start(0, 1, 0, 0, 32'h0000_9ABC, 6, -1);
        wait_done();

        // miss address churn after capture
        churn = 1; churn_fixed = 1;
        start(0, 1, 0, 0, 32'h0000_4444, -1, -1);
        wait_done();
        churn_fixed = 0;

        // random episodes
        junk = 1; fixed_beats = 0; stall_max = 3; gap_pct = 30; wready_pct = 60;
        for (int k = 0; k < 60; k++) begin
            int sel;
            sel = $urandom_range(2, 0);
            start(sel != 1, sel != 0, $urandom, {$urandom, $urandom, $urandom, $urandom}, $urandom, -1, -1);
            wait_done();
            repeat ($urandom_range(3, 0)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_refill_responder.md
# dcache_refill_responder

Memory-side responder for the data-cache miss-repair handshake. It accepts a held miss request from the cache controller and fetches the 128-bit block from main memory as four 32-bit beats. It returns the assembled block with a single-cycle `repair_resolved` pulse. It also drains dirty-block writebacks to memory, and a pending writeback always completes before any refill starts.

## Interface
- `ADDR_W`, 32, byte-address width.
- `BLOCK_BITS`, 128, cache block width.
- `BEAT_BITS`, 32, memory data beat width. BEATS = BLOCK_BITS/BEAT_BITS = 4, derived and fixed.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `miss_req` in 1: refill request, held high by the cache until `repair_resolved`.
- `miss_addr` in ADDR_W: missed address; any byte within the block.
- `repair_resolved` out 1: one-cycle pulse; `fill_addr`/`fill_data` are valid in this cycle.
- `fill_addr` out ADDR_W: block-aligned refill address (bits [3:0] = 0).
- `fill_data` out BLOCK_BITS: refilled block; beat i occupies [32i+31:32i].
- `wb_req` in 1: dirty-eviction writeback request, held until `wb_ack`.
- `wb_addr` in ADDR_W: eviction address.
- `wb_data` in BLOCK_BITS: evicted block.
- `wb_ack` out 1: one-cycle pulse when the writeback has fully drained.
- `mem_req_valid` out 1: memory command valid.
- `mem_req_ready` in 1: memory command accepted.
- `mem_req_we` out 1: 1 = write burst, 0 = read burst.
- `mem_req_addr` out ADDR_W: block-aligned burst address.
- `mem_wvalid` out 1: write beat valid.
- `mem_wready` in 1: write beat accepted.
- `mem_wdata` out BEAT_BITS: write beat data.
- `mem_rvalid` in 1: read beat valid. Has no backpressure; must be consumed every cycle it is high.
- `mem_rdata` in BEAT_BITS: read beat data.

## Operation
- **States:** IDLE, WB_REQ, WB_DATA, WB_DONE, RD_REQ, RD_DATA, RESP. A 2-bit beat counter `cnt`.
- **IDLE:**
  - If `wb_req`: capture `wb_addr` with [3:0] cleared, capture `wb_data`, go to WB_REQ.
  - Else if `miss_req`: capture `miss_addr` with [3:0] cleared, go to RD_REQ.
  - When both are high, writeback wins. `miss_req` stays held and is served after WB_DONE.
- **WB_REQ:** `mem_req_valid`=1, `mem_req_we`=1. On `mem_req_ready`, set `cnt`=0 and go to WB_DATA.
- **WB_DATA:** `mem_wvalid`=1, `mem_wdata` = captured block beat[`cnt`]. Each `mem_wready` increments `cnt`. Acceptance of beat 3 goes to WB_DONE.
- **WB_DONE:** `wb_ack`=1 for exactly this cycle, then go to IDLE.
- **RD_REQ:** `mem_req_valid`=1, `mem_req_we`=0. On `mem_req_ready`, set `cnt`=0, go to RD_DATA.
- **RD_DATA:**
  - Each `mem_rvalid` writes `mem_rdata` into beat[`cnt`] and increments `cnt`.
  - Beat 3 goes to RESP.
  - Gaps in `mem_rvalid` are tolerated.
- **RESP:** `repair_resolved`=1 for exactly this cycle, `fill_data` = assembled block, then go to IDLE.
- **`mem_req_addr`:** equals the captured address in WB_REQ/RD_REQ; 0 otherwise.
- **Held inputs:** `miss_addr`, `wb_addr` and `wb_data` changes after capture are ignored until the next IDLE.
- **Ignored inputs:**
  - `mem_rvalid` is ignored outside RD_DATA.
  - `mem_wready` is ignored outside WB_DATA.
  - `mem_req_ready` is ignored unless `mem_req_valid`=1.
- **Reset (including mid-burst):**
  - All state returns to IDLE; `cnt` = 0; captured registers = 0.
  - The burst is abandoned: no `repair_resolved` or `wb_ack` for it.
  - Stray memory beats after reset are dropped.

## Timing
- **Output reset values:** every output is 0 in the cycle after `rst` is sampled high, including `fill_data`/`fill_addr`.
- **Registered outputs:** all outputs decode from registered state and registered data; there are no combinational input-to-output paths.
- **Read latency:**
  - Memory returns the first read beat no earlier than the cycle after command acceptance.
  - Minimum miss latency, with `miss_req` seen in IDLE at cycle 0: RD_REQ at cycle 1 (accepted), beats at cycles 2–5, `repair_resolved` at cycle 6.
- **Writeback latency:** minimum is WB_REQ at 1, beats at 2–5, `wb_ack` at 6. A refill queued behind a writeback reaches RESP no earlier than cycle 13.
- **Cache handshake:**
  - The cache drops `miss_req` on the edge where it samples `repair_resolved`.
  - The responder returns to IDLE after RESP, so no duplicate refill occurs.
  - `fill_data` holds its value until the next RD_DATA beat.

## Test plan
- **Single miss:** `miss_addr`=0x0000_1234, memory ready immediately, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back -> `mem_req_addr`=0x0000_1230 with we=0; `repair_resolved` pulses at cycle 6; `fill_data`=0x44444444_33333333_22222222_11111111; `fill_addr`=0x0000_1230.
- **Stalled memory:** `mem_req_ready` low for 3 cycles, one-cycle gap between beats 1 and 2 -> identical `fill_data`; `repair_resolved` is one cycle wide and 4 cycles later than the single-miss case.
- **Writeback priority:** `wb_req` and `miss_req` high in the same cycle, `wb_addr`=0x80, `wb_data`=0xDDDD_CCCC_BBBB_AAAA (zero-extended) -> write burst first, with `mem_wdata` sequence 0xBBBBAAAA, 0xDDDDCCCC, 0, 0; `wb_ack` pulses; then a read burst; `repair_resolved` at cycle 13 minimum.
- **Write backpressure:** `mem_wready` toggles 1,0,1,0,... -> each beat is held stable while `mem_wready`=0; exactly 4 beats are accepted; one `wb_ack`.
- **Reset mid-read:** `rst` asserted after beat 2 -> all outputs 0 the next cycle; a following `mem_rvalid` is ignored; no `repair_resolved`; a new miss afterwards completes normally.
- **Input churn:** `miss_addr` changed to 0xFFFF_FFF0 during RD_DATA -> `fill_addr` keeps the originally captured address.
